// File: rtl/pulse_stretch_tx.sv
// Pulse-extender CDC transmit side: each event becomes a HIGH_CYC-wide level.
// Define STRETCH_OVF_FLAG_EN to add the ovf_sticky / ovf_clr saturation flag.
module pulse_stretch_tx #(
  parameter int HIGH_CYC = 3,
  parameter int LOW_CYC  = 3,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  output logic             stretch_out,
  output logic             busy,
  output logic [CNT_W-1:0] pending
`ifdef STRETCH_OVF_FLAG_EN
  ,
  output logic             ovf_sticky,
  input  logic             ovf_clr
`endif
);

  localparam int MAXC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [TW-1:0]    T_HI = TW'(HIGH_CYC - 1);
  localparam logic [TW-1:0]    T_LO = TW'(LOW_CYC - 1);
  localparam logic [CNT_W-1:0] PMAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HIGH,
    S_LOW
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TW-1:0]    r_timer;
  logic [TW-1:0]    w_timer_nxt;
  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] w_pend_nxt;
  logic             r_stretch;
  logic             r_busy;
  logic             w_acc;
  logic             w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_pend    <= '0;
      r_stretch <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_pend    <= w_pend_nxt;
      r_stretch <= (w_state_nxt == S_HIGH);
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pend_nxt  = r_pend;
    w_acc       = 1'b0;
    w_drop      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (pulse_in) begin
          w_state_nxt = S_HIGH;
          w_timer_nxt = T_HI;
        end
      end
      S_HIGH: begin
        w_acc = pulse_in;
        if (r_timer == '0) begin
          w_state_nxt = S_LOW;
          w_timer_nxt = T_LO;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      S_LOW: begin
        if (r_timer == '0) begin
          // A pulse on the exit edge either cancels the replay decrement
          // or chains straight into a new level instead of going idle.
          if (r_pend != '0 || pulse_in) begin
            w_state_nxt = S_HIGH;
            w_timer_nxt = T_HI;
            if (r_pend != '0 && !pulse_in) w_pend_nxt = r_pend - 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_acc       = pulse_in;
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
    if (w_acc) begin
      if (r_pend == PMAX) w_drop = 1'b1;
      else w_pend_nxt = r_pend + 1'b1;
    end
  end

  assign stretch_out = r_stretch;
  assign busy        = r_busy;
  assign pending     = r_pend;

`ifdef STRETCH_OVF_FLAG_EN
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (ovf_clr) r_ovf <= 1'b0;
  end

  assign ovf_sticky = r_ovf;
`else
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

endmodule
